// File: rtl/sys_pkg.sv
// Shared types and constants for the systolic MAC array slice.
package sys_pkg;
  localparam int DATA_W = 4;
  localparam int SUM_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    WLOAD,
    STREAM,
    DRAIN,
    DONE
  } feeder_state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/sys_skew_mux.sv
// Triangular skew select: lane j carries A[j][t-j] inside the wavefront.
module sys_skew_mux
  import sys_pkg::*;
#(
  parameter int row_width = 4,
  parameter int CW = 3
) (
  input  logic [row_width*row_width*DATA_W-1:0] a,
  input  logic [CW-1:0]                         t,
  output logic [row_width*DATA_W-1:0]           lanes
);
  for (genvar j = 0; j < row_width; j++) begin : g_lane
    logic [DATA_W-1:0] lane;
    always_comb begin
      lane = '0;
      for (int k = 0; k < row_width; k++)
        if (int'(t) == j + k)
          lane = a[(j*row_width+k)*DATA_W +: DATA_W];
    end
    assign lanes[j*DATA_W +: DATA_W] = lane;
  end
endmodule

// File: rtl/sys_feeder.sv
// Activation/weight feeder for the NxN systolic MAC array.
module sys_feeder
  import sys_pkg::*;
#(
  parameter int row_width = 4,
  localparam int AW = clog2(row_width),
  localparam int CW = clog2(2*row_width)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ld_en,
  input  logic                          ld_sel,
  input  logic [AW-1:0]                 ld_row,
  input  logic [AW-1:0]                 ld_col,
  input  logic [DATA_W-1:0]             ld_data,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic                          active,
  output logic [row_width*DATA_W-1:0]   data_out,
  output logic [row_width*DATA_W-1:0]   w_out,
  output logic [row_width*SUM_W-1:0]    sum_out,
  output logic [row_width-1:0]          weight_wren
);
  localparam int N = row_width;
  localparam int AF = N*N*DATA_W;
  localparam logic [CW-1:0] N_LAST = CW'(N-1);
  localparam logic [CW-1:0] S_LAST = CW'(2*N-2);

  feeder_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [AF-1:0] a_q, a_n;
  logic [N*DATA_W-1:0] w_q, w_n, skew;
  logic ld_ok;

  assign ld_ok = ld_en && (state == IDLE);
  assign sum_out = '0;

  // Constant-index compare keeps out-of-range rows/cols from writing.
  always_comb begin
    a_n = a_q;
    w_n = w_q;
    for (int c = 0; c < N; c++) begin
      if (ld_ok && ld_sel && int'(ld_col) == c)
        w_n[c*DATA_W +: DATA_W] = ld_data;
      for (int r = 0; r < N; r++)
        if (ld_ok && !ld_sel && int'(ld_row) == r &&
            int'(ld_col) == c)
          a_n[(r*N+c)*DATA_W +: DATA_W] = ld_data;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n = cnt + CW'(1);
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (start) state_n = WLOAD;
      end
      WLOAD:
        if (cnt == N_LAST) begin
          state_n = STREAM;
          cnt_n = '0;
        end
      STREAM:
        if (cnt == S_LAST) begin
          state_n = DRAIN;
          cnt_n = '0;
        end
      DRAIN:
        if (cnt == N_LAST) begin
          state_n = DONE;
          cnt_n = '0;
        end
      DONE: begin
        state_n = IDLE;
        cnt_n = '0;
      end
      default: begin
        state_n = IDLE;
        cnt_n = '0;
      end
    endcase
  end

  sys_skew_mux #(
    .row_width(N),
    .CW(CW)
  ) u_skew (
    .a(a_q),
    .t(cnt_n),
    .lanes(skew)
  );

  // Outputs are registered from next state so they align with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      a_q <= '0;
      w_q <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      active <= 1'b0;
      data_out <= '0;
      w_out <= '0;
      weight_wren <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      a_q <= a_n;
      w_q <= w_n;
      busy <= (state_n != IDLE);
      done <= (state_n == DONE);
      active <= (state_n == STREAM) || (state_n == DRAIN);
      weight_wren <= {N{state_n == WLOAD}};
      data_out <= (state_n == STREAM) ? skew : '0;
      w_out <= (state_n == IDLE) ? '0 : w_n;
    end
  end
endmodule
